// File: rtl/env_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : env_pkg
//  Description : Shared constants for the ADSR envelope / VCA voice stage:
//                sample width, full-scale envelope value and the state
//                encodings reported on the adsr_envelope state port.
//  Revision    : 1.0  initial release
// ============================================================================
package env_pkg;

    // Sample, envelope and step width
    localparam int W = 16;

    // Full-scale envelope value (2^W - 1)
    localparam logic [W-1:0] ENV_MAX = {W{1'b1}};

    // Envelope state encodings (5..7 are unreachable and fall back to IDLE)
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ATTACK  = 3'd1;
    localparam logic [2:0] ST_DECAY   = 3'd2;
    localparam logic [2:0] ST_SUSTAIN = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

endpackage
`default_nettype wire

// File: rtl/env_vca.sv
`default_nettype none
// ============================================================================
//  Module      : env_vca
//  Description : Registered VCA. On each tick, multiplies the unsigned
//                oscillator sample by the unsigned envelope and keeps the
//                upper half of the 2W-bit product. dout_valid pulses for one
//                clk alongside each new dout.
//  Ports       : clk        - system clock
//                rst_n      - synchronous active-low reset
//                tick       - sample-rate strobe
//                osc_in     - unsigned oscillator sample
//                env        - unsigned envelope (value before this tick's update)
//                dout       - registered upper half of osc_in * env
//                dout_valid - one-clk pulse marking a new dout
//  Revision    : 1.0  initial release
// ============================================================================
module env_vca
    import env_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic [W-1:0] osc_in,
    input  logic [W-1:0] env,
    output logic [W-1:0] dout,
    output logic         dout_valid
);

    logic [2*W-1:0] w_prod;
    logic [W-1:0]   r_dout;
    logic           r_valid;

    // Operands widened explicitly so the full 2W-bit product is kept
    assign w_prod = {{W{1'b0}}, osc_in} * {{W{1'b0}}, env};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dout  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= tick;
            if (tick) begin
                r_dout <= w_prod[2*W-1:W];
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/adsr_envelope.sv
`default_nettype none
// ============================================================================
//  Module      : adsr_envelope
//  Description : ADSR amplitude envelope generator with VCA output. The
//                envelope steps once per sample tick and never wraps: all
//                arithmetic is done W+1 bits wide and clamps to 0 / ENV_MAX.
//                The VCA multiplies osc_in by the pre-update envelope, so an
//                envelope change shows up in dout on the following tick.
//  Ports       : clk           - system clock
//                rst_n         - synchronous active-low reset
//                tick          - sample-rate strobe, one clk wide
//                gate          - note on/off, sampled on tick only
//                osc_in        - unsigned oscillator sample
//                attack_step   - increment per tick in ATTACK
//                decay_step    - decrement per tick in DECAY
//                sustain_level - hold level in SUSTAIN
//                release_step  - decrement per tick in RELEASE
//                env           - registered envelope value
//                state         - registered state encoding
//                dout          - registered VCA output
//                dout_valid    - one-clk pulse marking a new dout
//  Revision    : 1.0  initial release
// ============================================================================
module adsr_envelope
    import env_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic         gate,
    input  logic [W-1:0] osc_in,
    input  logic [W-1:0] attack_step,
    input  logic [W-1:0] decay_step,
    input  logic [W-1:0] sustain_level,
    input  logic [W-1:0] release_step,
    output logic [W-1:0] env,
    output logic [2:0]   state,
    output logic [W-1:0] dout,
    output logic         dout_valid
);

    logic [2:0]   r_state;
    logic [2:0]   w_state_nxt;
    logic [W-1:0] r_env;
    logic [W-1:0] w_env_nxt;
    logic [W:0]   w_att_sum;
    logic [W:0]   w_dec_thr;

    // One extra bit so neither the attack sum nor the decay threshold wraps
    assign w_att_sum = {1'b0, r_env} + {1'b0, attack_step};
    assign w_dec_thr = {1'b0, sustain_level} + {1'b0, decay_step};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_env   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_env   <= w_env_nxt;
        end
    end

    // Gate checks come first in each state so a gate edge wins over a
    // threshold crossing on the same tick.
    always_comb begin
        w_state_nxt = r_state;
        w_env_nxt   = r_env;
        if (tick) begin
            case (r_state)
                ST_IDLE: begin
                    w_env_nxt = '0;
                    if (gate) begin
                        w_state_nxt = ST_ATTACK;
                    end
                end
                ST_ATTACK: begin
                    if (!gate) begin
                        w_state_nxt = ST_RELEASE;
                    end else if ((attack_step == '0) || (w_att_sum >= {1'b0, ENV_MAX})) begin
                        w_env_nxt   = ENV_MAX;
                        w_state_nxt = ST_DECAY;
                    end else begin
                        w_env_nxt = w_att_sum[W-1:0];
                    end
                end
                ST_DECAY: begin
                    if (!gate) begin
                        w_state_nxt = ST_RELEASE;
                    end else if ((decay_step == '0) || ({1'b0, r_env} <= w_dec_thr)) begin
                        // Also catches sustain_level raised above env mid-decay
                        w_env_nxt   = sustain_level;
                        w_state_nxt = ST_SUSTAIN;
                    end else begin
                        w_env_nxt = r_env - decay_step;
                    end
                end
                ST_SUSTAIN: begin
                    if (!gate) begin
                        w_state_nxt = ST_RELEASE;
                    end else begin
                        w_env_nxt = sustain_level;
                    end
                end
                ST_RELEASE: begin
                    if (gate) begin
                        // Retrigger continues from the current level
                        w_state_nxt = ST_ATTACK;
                    end else if ((release_step == '0) || (r_env <= release_step)) begin
                        w_env_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_env_nxt = r_env - release_step;
                    end
                end
                default: begin
                    w_env_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // VCA sees the envelope before this tick's update
    env_vca u_vca (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .osc_in     (osc_in),
        .env        (r_env),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    assign env   = r_env;
    assign state = r_state;

endmodule
`default_nettype wire
